regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Writer-side companion to the 32x32 register file. Owns the single write port (wr_en/rd/data).
- Merges single-cycle ALU results with variable-latency load responses from data memory.
- Keeps a per-register pending-load scoreboard so decode can stall on RAW/WAW hazards against in-flight loads.
- Sits between execute/memory and the register file in the RISC-V core.

Parameters:
- XLEN, 32, data width of the write port and of ALU/load data.
- LQ_DEPTH, 2, entries in the load-response holding queue (power of 2, >=1).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_wr_en_i  input  1  ALU result valid this cycle.
- alu_rd_i  input  5  ALU destination register.
- alu_data_i  input  XLEN  ALU result.
- ld_issue_i  input  1  decode issues a load this cycle (sets scoreboard).
- ld_rd_i  input  5  destination of the issued load.
- ld_rsp_valid_i  input  1  memory load response valid.
- ld_rsp_rd_i  input  5  destination of the response.
- ld_rsp_data_i  input  XLEN  load data.
- ld_rsp_ready_o  output  1  block can accept a response.
- dec_rs1_i  input  5  decode source 1 address.
- dec_rs2_i  input  5  decode source 2 address.
- dec_rd_i  input  5  decode destination address.
- stall_o  output  1  decode must hold.
- wr_en_o  output  1  register file write enable.
- rd_addr_o  output  5  register file write address.
- wr_data_o  output  XLEN  register file write data.

Behaviour:
- Reset (reset=1 at an edge):
  - wr_en_o=0, rd_addr_o=0, wr_data_o=0.
  - Scoreboard busy[31:0]=0; queue emptied.
  - ld_rsp_ready_o=0 while reset is high.
  - Reset mid-operation discards queued and in-flight loads with no write.
- Output registers, 1-cycle latency: a source selected in cycle N drives wr_en_o/rd_addr_o/wr_data_o for cycle N+1 only.
- Source priority per cycle:
  - ALU first.
  - Then queue head.
  - Then a load response accepted this cycle with the queue empty (direct path).
- Load responses:
  - Accepted when ld_rsp_valid_i & ld_rsp_ready_o.
  - An accepted response not sent out directly is enqueued.
  - Queue pops only in cycles with no ALU write.
  - Simultaneous pop and enqueue is allowed.
- ld_rsp_ready_o = !reset & (count < LQ_DEPTH). When full, memory holds the response; nothing is dropped.
- x0 writes:
  - alu_rd_i=0 or a load with rd=0 never raises wr_en_o.
  - A rd=0 load response is still consumed and dequeued normally.
- Scoreboard:
  - ld_issue_i with ld_rd_i!=0 sets busy[ld_rd_i].
  - busy[r] clears in the cycle a load write to r is registered onto the output.
  - Set and clear of the same r in one cycle: set wins.
- stall_o (combinational) = busy[dec_rs1_i] | busy[dec_rs2_i] | busy[dec_rd_i], with index 0 always reading 0.
  - Without WB_BYPASS_EN, stall_o additionally ORs (wr_en_o & rd_addr_o!=0 & rd_addr_o in {dec_rs1_i, dec_rs2_i}).
- Write ordering:
  - Decode must not issue a load while stall_o=1.
  - A load and a later ALU op to the same rd cannot coexist, because of the dec_rd_i term.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: adds outputs fwd1_hit_o, fwd1_data_o, fwd2_hit_o, fwd2_data_o.
  - fwdN_hit_o = wr_en_o & rd_addr_o!=0 & rd_addr_o==dec_rsN_i.
  - fwdN_data_o = wr_data_o.
  - The write-in-flight stall term is removed.
- Undefined: no forwarding ports; the write-in-flight term is included in stall_o.

Test Plan:
- Reset, then alu_wr_en_i=1, rd=5, data=32'hDEADBEEF in cycle N -> wr_en_o=1, rd_addr_o=5, wr_data_o=32'hDEADBEEF in N+1 only; wr_en_o=0 in N+2.
- ld_issue_i rd=7, then dec_rs1_i=7 -> stall_o=1. Response rd=7, data=32'h12345678, no ALU -> write next cycle; busy[7] cleared; stall_o=0.
- ALU write rd=3 held for 3 cycles while 3 load responses (rd 8,9,10) arrive, LQ_DEPTH=2:
  - 2 enqueued, ld_rsp_ready_o=0 on the third.
  - After the ALU stops, writes 8, 9, 10 occur in order, one per cycle.
- alu_rd_i=0 and a load response with rd=0 -> wr_en_o stays 0; the response is consumed and ready returns high.
- Reset asserted with 2 queued loads and busy[4]=1 -> no writes follow; busy=0; ld_rsp_ready_o=0 during reset, then 1 after.
- ALU write rd=6 then dec_rs2_i=6 next cycle:
  - Without WB_BYPASS_EN, stall_o=1 for that cycle.
  - With it, stall_o=0, fwd2_hit_o=1, fwd2_data_o=written value.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Write-back bus: ALU results, load issue/response, decode hazard query, register-file write port.
// WB_BYPASS_EN adds the decode forwarding outputs.
interface regfile_writeback_if #(
  parameter int XLEN = 32
);
  logic            alu_wr_en_i;
  logic [4:0]      alu_rd_i;
  logic [XLEN-1:0] alu_data_i;
  logic            ld_issue_i;
  logic [4:0]      ld_rd_i;
  logic            ld_rsp_valid_i;
  logic [4:0]      ld_rsp_rd_i;
  logic [XLEN-1:0] ld_rsp_data_i;
  logic            ld_rsp_ready_o;
  logic [4:0]      dec_rs1_i;
  logic [4:0]      dec_rs2_i;
  logic [4:0]      dec_rd_i;
  logic            stall_o;
  logic            wr_en_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] wr_data_o;
`ifdef WB_BYPASS_EN
  logic            fwd1_hit_o;
  logic [XLEN-1:0] fwd1_data_o;
  logic            fwd2_hit_o;
  logic [XLEN-1:0] fwd2_data_o;
`endif

  modport master (
    output alu_wr_en_i, alu_rd_i, alu_data_i,
    output ld_issue_i, ld_rd_i,
    output ld_rsp_valid_i, ld_rsp_rd_i, ld_rsp_data_i,
    output dec_rs1_i, dec_rs2_i, dec_rd_i,
    input  ld_rsp_ready_o, stall_o, wr_en_o, rd_addr_o, wr_data_o
`ifdef WB_BYPASS_EN
    , input fwd1_hit_o, fwd1_data_o, fwd2_hit_o, fwd2_data_o
`endif
  );

  modport slave (
    input  alu_wr_en_i, alu_rd_i, alu_data_i,
    input  ld_issue_i, ld_rd_i,
    input  ld_rsp_valid_i, ld_rsp_rd_i, ld_rsp_data_i,
    input  dec_rs1_i, dec_rs2_i, dec_rd_i,
    output ld_rsp_ready_o, stall_o, wr_en_o, rd_addr_o, wr_data_o
`ifdef WB_BYPASS_EN
    , output fwd1_hit_o, fwd1_data_o, fwd2_hit_o, fwd2_data_o
`endif
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write port: ALU > queued load > direct load, 1-cycle registered output, pending-load scoreboard.
// Backpressure: ld_rsp_ready_o drops when the load queue is full or in reset; WB_BYPASS_EN adds forwarding.
module regfile_writeback #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  regfile_writeback_if.slave wb
);
  localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(LQ_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(LQ_DEPTH - 1);

  logic [4:0]      lq_rd_q   [LQ_DEPTH];
  logic [4:0]      lq_rd_d   [LQ_DEPTH];
  logic [XLEN-1:0] lq_data_q [LQ_DEPTH];
  logic [XLEN-1:0] lq_data_d [LQ_DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic            rsp_rdy, rsp_acc, push, pop, ld_sel, sel_vld;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  assign rsp_rdy = !reset && (count_q < DEPTH_C);
  assign rsp_acc = wb.ld_rsp_valid_i && rsp_rdy;

  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    ld_sel   = 1'b0;
    sel_vld  = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (wb.alu_wr_en_i) begin
      sel_vld  = 1'b1;
      sel_rd   = wb.alu_rd_i;
      sel_data = wb.alu_data_i;
      push     = rsp_acc;
    end else if (count_q != '0) begin
      sel_vld  = 1'b1;
      ld_sel   = 1'b1;
      pop      = 1'b1;
      sel_rd   = lq_rd_q[head_q];
      sel_data = lq_data_q[head_q];
      push     = rsp_acc;
    end else if (rsp_acc) begin
      // Empty queue: the response bypasses storage and goes straight out.
      sel_vld  = 1'b1;
      ld_sel   = 1'b1;
      sel_rd   = wb.ld_rsp_rd_i;
      sel_data = wb.ld_rsp_data_i;
    end
    wr_en_d   = sel_vld && (sel_rd != 5'd0);
    rd_addr_d = wr_en_d ? sel_rd : 5'd0;
    wr_data_d = wr_en_d ? sel_data : '0;
  end

  always_comb begin
    lq_rd_d   = lq_rd_q;
    lq_data_d = lq_data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (push) begin
      lq_rd_d[tail_q]   = wb.ld_rsp_rd_i;
      lq_data_d[tail_q] = wb.ld_rsp_data_i;
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
    end
    if (pop) begin
      head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // A new issue to r overrides the clear of an older load to r in the same cycle.
  always_comb begin
    busy_d = busy_q;
    if (ld_sel && (sel_rd != 5'd0)) busy_d[sel_rd] = 1'b0;
    if (wb.ld_issue_i && (wb.ld_rd_i != 5'd0)) busy_d[wb.ld_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= 5'd0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    lq_rd_q   <= lq_rd_d;
    lq_data_q <= lq_data_d;
  end

  assign wb.ld_rsp_ready_o = rsp_rdy;
  assign wb.wr_en_o        = wr_en_q;
  assign wb.rd_addr_o      = rd_addr_q;
  assign wb.wr_data_o      = wr_data_q;

`ifdef WB_BYPASS_EN
  assign wb.fwd1_hit_o  = wr_en_q && (rd_addr_q != 5'd0) && (rd_addr_q == wb.dec_rs1_i);
  assign wb.fwd1_data_o = wr_data_q;
  assign wb.fwd2_hit_o  = wr_en_q && (rd_addr_q != 5'd0) && (rd_addr_q == wb.dec_rs2_i);
  assign wb.fwd2_data_o = wr_data_q;
  assign wb.stall_o = busy_q[wb.dec_rs1_i] | busy_q[wb.dec_rs2_i] | busy_q[wb.dec_rd_i];
`else
  // Without forwarding, a source being written this cycle is not yet readable.
  assign wb.stall_o = busy_q[wb.dec_rs1_i] | busy_q[wb.dec_rs2_i] | busy_q[wb.dec_rd_i]
                    | (wr_en_q && (rd_addr_q != 5'd0) &&
                       ((rd_addr_q == wb.dec_rs1_i) || (rd_addr_q == wb.dec_rs2_i)));
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized and directed bench for regfile_writeback against a queue/array reference model.
module tb_regfile_writeback;
  localparam int XLEN = 32;
  localparam int LQD  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_writeback_if #(.XLEN(XLEN)) bus();
  regfile_writeback #(.XLEN(XLEN), .LQ_DEPTH(LQD)) dut (
    .clk  (clk),
    .reset(reset),
    .wb   (bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } rsp_t;

  logic        s_reset;
  logic        s_alu_en, s_iss, s_rv;
  logic [4:0]  s_alu_rd, s_iss_rd, s_rrd, s_rs1, s_rs2, s_drd;
  logic [31:0] s_alu_data, s_rdata;

  rsp_t        m_q[$];
  bit          m_busy[32];
  bit          e_wr;
  logic [4:0]  e_rd;
  logic [31:0] e_data;
  bit          m_acc;
  logic [4:0]  out_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_stall(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] drd);
    bit s;
    s = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]) || (drd != 0 && m_busy[drd]);
`ifndef WB_BYPASS_EN
    s = s || (e_wr && e_rd != 0 && (e_rd == rs1 || e_rd == rs2));
`endif
    return s;
  endfunction

  task automatic model_update();
    rsp_t e;
    bit ld_w;
    logic [4:0] ld_rd;
    int sz;
    ld_w = 0;
    ld_rd = 0;
    if (s_reset) begin
      m_q.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
      e_wr = 0; e_rd = 0; e_data = 0; m_acc = 0;
      return;
    end
    sz = m_q.size();
    m_acc = s_rv && (sz < LQD);
    if (s_alu_en) begin
      e_wr = (s_alu_rd != 0); e_rd = s_alu_rd; e_data = s_alu_data;
      if (m_acc) m_q.push_back({s_rrd, s_rdata});
    end else if (sz > 0) begin
      e = m_q.pop_front();
      e_wr = (e.rd != 0); e_rd = e.rd; e_data = e.data;
      ld_w = 1; ld_rd = e.rd;
      if (m_acc) m_q.push_back({s_rrd, s_rdata});
    end else if (m_acc) begin
      e_wr = (s_rrd != 0); e_rd = s_rrd; e_data = s_rdata;
      ld_w = 1; ld_rd = s_rrd;
    end else begin
      e_wr = 0;
    end
    if (ld_w) m_busy[ld_rd] = 0;
    if (s_iss && s_iss_rd != 0) m_busy[s_iss_rd] = 1;
  endtask

  task automatic drive();
    reset              = s_reset;
    bus.alu_wr_en_i    = s_alu_en;
    bus.alu_rd_i       = s_alu_rd;
    bus.alu_data_i     = s_alu_data;
    bus.ld_issue_i     = s_iss;
    bus.ld_rd_i        = s_iss_rd;
    bus.ld_rsp_valid_i = s_rv;
    bus.ld_rsp_rd_i    = s_rrd;
    bus.ld_rsp_data_i  = s_rdata;
    bus.dec_rs1_i      = s_rs1;
    bus.dec_rs2_i      = s_rs2;
    bus.dec_rd_i       = s_drd;
  endtask

  // One cycle: drive at negedge, compare every output against the model, then advance the model.
  task automatic cyc();
    @(negedge clk);
    drive();
    #1;
    chk("ready", bus.ld_rsp_ready_o, (!s_reset && m_q.size() < LQD));
    chk("stall", bus.stall_o, m_stall(s_rs1, s_rs2, s_drd));
    chk("wr_en", bus.wr_en_o, e_wr);
    if (e_wr) begin
      chk("rd_addr", bus.rd_addr_o, e_rd);
      chk("wr_data", bus.wr_data_o, e_data);
    end
`ifdef WB_BYPASS_EN
    chk("fwd1_hit", bus.fwd1_hit_o, e_wr && e_rd != 0 && e_rd == s_rs1);
    chk("fwd2_hit", bus.fwd2_hit_o, e_wr && e_rd != 0 && e_rd == s_rs2);
    if (bus.fwd1_hit_o) chk("fwd1_data", bus.fwd1_data_o, e_data);
    if (bus.fwd2_hit_o) chk("fwd2_data", bus.fwd2_data_o, e_data);
`endif
    model_update();
  endtask

  task automatic idle();
    s_alu_en = 0; s_alu_rd = 0; s_alu_data = 0;
    s_iss = 0; s_iss_rd = 0;
    s_rv = 0; s_rrd = 0; s_rdata = 0;
    s_rs1 = 0; s_rs2 = 0; s_drd = 0;
  endtask

  task automatic issue(input logic [4:0] r);
    idle(); s_iss = 1; s_iss_rd = r; cyc();
  endtask

  initial begin
    s_reset = 1; idle(); drive();
    e_wr = 0; e_rd = 0; e_data = 0; m_acc = 0;

    cyc(); cyc();
    chk("lit_ready_in_reset", bus.ld_rsp_ready_o, 0);
    chk("lit_wr_en_after_reset", bus.wr_en_o, 0);
    s_reset = 0;

    // ALU write appears for exactly one cycle.
    idle(); s_alu_en = 1; s_alu_rd = 5; s_alu_data = 32'hDEADBEEF; cyc();
    idle(); cyc();
    chk("lit_alu_wr_en", bus.wr_en_o, 1);
    chk("lit_alu_rd", bus.rd_addr_o, 5);
    chk("lit_alu_data", bus.wr_data_o, 32'hDEADBEEF);
    idle(); cyc();
    chk("lit_alu_one_cycle", bus.wr_en_o, 0);

    // Load to x7: stall while pending, direct-path write clears it.
    issue(7);
    idle(); s_rs1 = 7; cyc();
    chk("lit_stall_busy7", bus.stall_o, 1);
    idle(); s_rs1 = 7; s_rv = 1; s_rrd = 7; s_rdata = 32'h12345678; cyc();
    chk("lit_ready_direct", bus.ld_rsp_ready_o, 1);
    idle(); s_rs1 = 7; cyc();
    chk("lit_ld_wr_en", bus.wr_en_o, 1);
    chk("lit_ld_rd", bus.rd_addr_o, 7);
    chk("lit_ld_data", bus.wr_data_o, 32'h12345678);
`ifdef WB_BYPASS_EN
    chk("lit_stall_wr7_bypass", bus.stall_o, 0);
`else
    chk("lit_stall_wr7_inflight", bus.stall_o, 1);
`endif
    idle(); s_rs1 = 7; cyc();
    chk("lit_stall_cleared", bus.stall_o, 0);

    // ALU held over three responses: queue fills, then drains in order.
    issue(8); issue(9); issue(10);
    for (int i = 0; i < 3; i++) begin
      idle(); s_alu_en = 1; s_alu_rd = 3; s_alu_data = 32'h33;
      s_rv = 1; s_rrd = 5'(8 + i); s_rdata = 32'(108 + i); cyc();
    end
    chk("lit_ready_full", bus.ld_rsp_ready_o, 0);
    idle(); s_rv = 1; s_rrd = 10; s_rdata = 110; cyc();
    chk("lit_ready_still_full", bus.ld_rsp_ready_o, 0);
    idle(); s_rv = 1; s_rrd = 10; s_rdata = 110; cyc();
    chk("lit_ready_reopen", bus.ld_rsp_ready_o, 1);
    chk("lit_drain_rd8", bus.rd_addr_o, 8);
    idle(); cyc();
    chk("lit_drain_rd9", bus.rd_addr_o, 9);
    idle(); cyc();
    chk("lit_drain_rd10", bus.rd_addr_o, 10);
    chk("lit_drain_data10", bus.wr_data_o, 110);

    // x0 writes from both sources are suppressed; the response is still consumed.
    idle(); s_alu_en = 1; s_alu_rd = 0; s_alu_data = 32'h55;
    s_rv = 1; s_rrd = 0; s_rdata = 32'h66; cyc();
    idle(); cyc();
    chk("lit_x0_alu", bus.wr_en_o, 0);
    idle(); cyc();
    chk("lit_x0_load", bus.wr_en_o, 0);
    chk("lit_x0_ready", bus.ld_rsp_ready_o, 1);

    // Reset with two queued loads and busy[4].
    issue(4); issue(11); issue(12);
    idle(); s_alu_en = 1; s_alu_rd = 3; s_alu_data = 1; s_rv = 1; s_rrd = 11; s_rdata = 111; cyc();
    idle(); s_alu_en = 1; s_alu_rd = 3; s_alu_data = 2; s_rv = 1; s_rrd = 12; s_rdata = 112; cyc();
    idle(); s_reset = 1; cyc();
    chk("lit_ready_mid_reset", bus.ld_rsp_ready_o, 0);
    s_reset = 0;
    for (int i = 0; i < 3; i++) begin
      idle(); s_rs1 = 4; s_drd = 4; cyc();
      chk("lit_no_write_after_reset", bus.wr_en_o, 0);
      chk("lit_busy4_cleared", bus.stall_o, 0);
      chk("lit_ready_after_reset", bus.ld_rsp_ready_o, 1);
    end

    // ALU write followed by a decode reading it.
    idle(); s_alu_en = 1; s_alu_rd = 6; s_alu_data = 32'hCAFE0006; cyc();
    idle(); s_rs2 = 6; cyc();
`ifdef WB_BYPASS_EN
    chk("lit_fwd_stall", bus.stall_o, 0);
    chk("lit_fwd2_hit", bus.fwd2_hit_o, 1);
    chk("lit_fwd2_data", bus.fwd2_data_o, 32'hCAFE0006);
`else
    chk("lit_inflight_stall", bus.stall_o, 1);
`endif

    // Randomized traffic obeying decode rules.
    idle(); s_reset = 1; cyc(); s_reset = 0;
    out_q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] r;
      if (!s_rv) begin
        s_rv = 0;
        if (out_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          s_rv = 1; s_rrd = out_q[0]; s_rdata = $urandom;
        end
      end
      s_rs1 = 5'($urandom_range(0, 7));
      s_rs2 = 5'($urandom_range(0, 7));
      s_drd = 5'($urandom_range(0, 7));
      s_iss = 0; s_iss_rd = 0;
      if (!m_stall(s_rs1, s_rs2, s_drd) && $urandom_range(0, 1) == 1) begin
        s_iss = 1; s_iss_rd = s_drd;
      end
      r = 5'($urandom_range(0, 7));
      s_alu_en = 0; s_alu_rd = r; s_alu_data = $urandom;
      if (!m_busy[r] && $urandom_range(0, 1) == 1) s_alu_en = 1;
      s_reset = ($urandom_range(0, 249) == 0);
      if (s_reset) begin
        s_rv = 0; s_iss = 0; out_q.delete();
      end
      if (s_iss) out_q.push_back(s_iss_rd);
      cyc();
      if (s_rv && m_acc) begin
        void'(out_q.pop_front());
        s_rv = 0;
      end
      s_reset = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
